// File: rtl/pcm_mute_ramp.sv
// rtl/pcm_mute_ramp.sv - soft-mute linear gain ramp on stereo PCM frames, one-cycle latency
// Optional build macro PCM_MUTE_RAMP_ROUND_EN selects round-half-up scaling instead of floor.
module pcm_mute_ramp #(
  parameter int RAMP_LOG2 = 6,
  parameter int CH_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*CH_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                mute_req,
  output logic [2*CH_W-1:0]   out_data,
  output logic                out_valid,
  output logic                muted,
  output logic                ramping
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = CH_W + GW + 1;
  localparam logic [GW-1:0] G_MAX  = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0] G_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};
  localparam logic [GW-1:0] G_ZERO = '0;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    DOWN  = 2'd1,
    MUTED = 2'd2,
    UP    = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [GW-1:0] g, g_next;

  // Signed channel times unsigned gain, widened so neither sign nor magnitude is lost.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch,
                                            input logic [GW-1:0]   gain);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    logic signed [PW-1:0] p;
    a = $signed({{(GW + 1){ch[CH_W-1]}}, ch});
    b = $signed({{(CH_W + 1){1'b0}}, gain});
    p = a * b;
`ifdef PCM_MUTE_RAMP_ROUND_EN
    p = p + (PW'(1) <<< (RAMP_LOG2 - 1));
`else
    p = p + PW'(0);
`endif
    return CH_W'(p >>> RAMP_LOG2);
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      PASS:  if (mute_req) state_next = DOWN;
      DOWN: begin
        if (!mute_req)                       state_next = UP;
        else if (in_valid && (g <= G_ONE))   state_next = MUTED;
      end
      MUTED: if (!mute_req) state_next = UP;
      UP: begin
        if (mute_req)                               state_next = DOWN;
        else if (in_valid && (g >= G_MAX - G_ONE))  state_next = PASS;
      end
      default: state_next = MUTED;
    endcase
  end

  // The step direction follows the state being entered, so a coincident frame reverses cleanly.
  always_comb begin
    g_next = g;
    if (in_valid) begin
      if ((state_next == DOWN || state_next == MUTED) && g != G_ZERO)
        g_next = g - G_ONE;
      else if ((state_next == UP || state_next == PASS) && g != G_MAX)
        g_next = g + G_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MUTED;
      g         <= G_ZERO;
      out_data  <= '0;
      out_valid <= 1'b0;
      muted     <= 1'b1;
      ramping   <= 1'b0;
    end else begin
      state     <= state_next;
      g         <= g_next;
      out_valid <= in_valid;
      if (in_valid)
        out_data <= {scale(in_data[2*CH_W-1:CH_W], g), scale(in_data[CH_W-1:0], g)};
      muted     <= (state_next == MUTED);
      ramping   <= (state_next == DOWN) || (state_next == UP);
    end
  end

endmodule

// File: tb/tb_pcm_mute_ramp.sv
// tb/tb_pcm_mute_ramp.sv - directed self-checking bench for pcm_mute_ramp
module tb_pcm_mute_ramp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        mute_req = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        muted;
  logic        ramping;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] HALF_POS = 32'h4000_0000;
  localparam logic [31:0] HALF_NEG = 32'hC000_0000;
  localparam logic [31:0] STEP     = 32'h0100_0000;

  pcm_mute_ramp #(.RAMP_LOG2(6), .CH_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .mute_req (mute_req),
    .out_data (out_data),
    .out_valid(out_valid),
    .muted    (muted),
    .ramping  (ramping)
  );

  always #5 clk = ~clk;

  // Frame registered on the posedge in between; outputs are sampled on the returning negedge.
  task automatic send(input logic [63:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic set_mute(input logic m);
    @(negedge clk);
    mute_req = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    mute_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || muted !== 1'b1 || ramping !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got v=%b d=%h m=%b r=%b, want v=0 d=0 m=1 r=0",
               out_valid, out_data, muted, ramping);
    end
    @(negedge clk);
    n_cmp++;
    if (muted !== 1'b0 || ramping !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_enter_up: got m=%b r=%b, want m=0 r=1", muted, ramping);
    end
  endtask

  task automatic test_fade_in();
    logic [31:0] el;
    for (int k = 0; k < 64; k++) begin
      send({HALF_POS, HALF_NEG});
      el = 32'(k) * STEP;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== {el, -el}) begin
        n_bad++;
        $display("FAIL fade_in_%0d: got v=%b d=%h, want v=1 d=%h", k, out_valid, out_data, {el, -el});
      end
    end
    n_cmp++;
    if (muted !== 1'b0 || ramping !== 1'b0) begin
      n_bad++;
      $display("FAIL fade_in_pass_flags: got m=%b r=%b, want m=0 r=0", muted, ramping);
    end
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_data !== {HALF_POS, HALF_NEG}) begin
      n_bad++;
      $display("FAIL fade_in_unity: got %h, want %h", out_data, {HALF_POS, HALF_NEG});
    end
  endtask

  task automatic test_fade_out();
    logic [31:0] el;
    set_mute(1'b1);
    for (int k = 0; k < 64; k++) begin
      send({HALF_POS, HALF_NEG});
      el = 32'(64 - k) * STEP;
      n_cmp++;
      if (out_data !== {el, -el}) begin
        n_bad++;
        $display("FAIL fade_out_%0d: got %h, want %h", k, out_data, {el, -el});
      end
    end
    n_cmp++;
    if (muted !== 1'b1 || ramping !== 1'b0) begin
      n_bad++;
      $display("FAIL fade_out_muted: got m=%b r=%b, want m=1 r=0", muted, ramping);
    end
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 64'd0) begin
      n_bad++;
      $display("FAIL muted_zero: got v=%b d=%h, want v=1 d=0", out_valid, out_data);
    end
  endtask

  task automatic test_reversal();
    set_mute(1'b0);
    for (int k = 0; k < 40; k++) send({HALF_POS, HALF_NEG});
    set_mute(1'b1);
    for (int k = 0; k < 8; k++) send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_data[63:32] !== 32'h2100_0000) begin
      n_bad++;
      $display("FAIL reversal_down_g33: got %h, want 21000000", out_data[63:32]);
    end
    set_mute(1'b0);
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_data !== {32'h2000_0000, 32'hE000_0000}) begin
      n_bad++;
      $display("FAIL reversal_g32: got %h, want 20000000e0000000", out_data);
    end
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_data[63:32] !== 32'h2100_0000 || ramping !== 1'b1) begin
      n_bad++;
      $display("FAIL reversal_g33: got d=%h r=%b, want d=21000000 r=1", out_data[63:32], ramping);
    end
  endtask

  task automatic test_negative_rounding();
    logic [31:0] exp_one;
`ifdef PCM_MUTE_RAMP_ROUND_EN
    exp_one = 32'd1;
`else
    exp_one = 32'd0;
`endif
    do_reset();
    send({HALF_POS, HALF_NEG});
    send({32'hFFFF_FFC0, 32'hFFFF_FFC0});
    n_cmp++;
    if (out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL neg_g1: got %h, want ffffffffffffffff", out_data);
    end
    for (int k = 0; k < 30; k++) send({HALF_POS, HALF_NEG});
    send({32'd1, HALF_POS});
    n_cmp++;
    if (out_data !== {exp_one, 32'h2000_0000}) begin
      n_bad++;
      $display("FAIL round_g32: got %h, want %h", out_data, {exp_one, 32'h2000_0000});
    end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    for (int k = 0; k < 20; k++) send({HALF_POS, HALF_NEG});
    @(negedge clk);
    reset    = 1'b1;
    in_data  = {HALF_POS, HALF_NEG};
    in_valid = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || muted !== 1'b1 || ramping !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b d=%h m=%b r=%b, want v=0 d=0 m=1 r=0",
               out_valid, out_data, muted, ramping);
    end
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 64'd0) begin
      n_bad++;
      $display("FAIL mid_reset_g0: got v=%b d=%h, want v=1 d=0", out_valid, out_data);
    end
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_data !== {STEP, -STEP}) begin
      n_bad++;
      $display("FAIL mid_reset_g1: got %h, want %h", out_data, {STEP, -STEP});
    end
  endtask

  task automatic test_coincident();
    do_reset();
    for (int k = 0; k < 64; k++) send({HALF_POS, HALF_NEG});
    @(negedge clk);
    mute_req = 1'b1;
    in_data  = {HALF_POS, HALF_NEG};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_data !== {HALF_POS, HALF_NEG} || ramping !== 1'b1) begin
      n_bad++;
      $display("FAIL coincident_unity: got d=%h r=%b, want d=%h r=1", out_data, ramping, {HALF_POS, HALF_NEG});
    end
    send({HALF_POS, HALF_NEG});
    n_cmp++;
    if (out_data[63:32] !== 32'h3F00_0000) begin
      n_bad++;
      $display("FAIL coincident_g63: got %h, want 3f000000", out_data[63:32]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_data  = {HALF_POS, HALF_NEG};
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data[63:32] !== 32'h3E00_0000) begin
      n_bad++;
      $display("FAIL b2b_first: got v=%b d=%h, want v=1 d=3e000000", out_valid, out_data[63:32]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data[63:32] !== 32'h3D00_0000) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b d=%h, want v=1 d=3d000000", out_valid, out_data[63:32]);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data[63:32] !== 32'h3D00_0000) begin
      n_bad++;
      $display("FAIL b2b_hold: got v=%b d=%h, want v=0 d=3d000000", out_valid, out_data[63:32]);
    end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_fade_out();
    test_reversal();
    test_negative_rounding();
    test_reset_mid_ramp();
    test_coincident();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
